// File: rtl/frame_scheduler.sv
// 16x8 frame shadow buffer with round-robin write arbitration, line-clear shifter and a
// free-running display refresh scan. Optional auto-clear of full rows: FRAME_SCHED_AUTOCLEAR_EN.
module frame_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr0_valid,
    input  logic [3:0]  wr0_addr,
    input  logic [7:0]  wr0_data,
    output logic        wr0_ready,
    input  logic        wr1_valid,
    input  logic [3:0]  wr1_addr,
    input  logic [7:0]  wr1_data,
    output logic        wr1_ready,
    input  logic        clr_valid,
    input  logic [3:0]  clr_row,
    output logic        clr_ready,
    output logic        clr_done,
    output logic        busy,
    output logic [15:0] row_full,
    output logic [3:0]  address,
    output logic [7:0]  print
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_shadow [16];
    logic [3:0] r_scan;
    logic [3:0] r_cur;
    logic       r_ptr;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_start_clear;
    logic [3:0] w_clr_target;
    logic       w_auto;
    logic [3:0] w_auto_row;

    always_comb begin
        row_full = '0;
        for (int unsigned i = 0; i < 16; i++)
            row_full[i] = (r_shadow[i] == 8'hFF);
    end

`ifdef FRAME_SCHED_AUTOCLEAR_EN
    // Ascending scan so the highest-index full row wins.
    always_comb begin
        w_auto_row = '0;
        for (int unsigned i = 0; i < 16; i++)
            if (row_full[i]) w_auto_row = 4'(i);
    end
    assign w_auto = |row_full;
`else
    assign w_auto     = 1'b0;
    assign w_auto_row = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (clr_valid || w_auto) w_next = CLEAR;
            CLEAR:   if (r_cur == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        clr_ready     = 1'b0;
        clr_done      = 1'b0;
        busy          = 1'b0;
        w_start_clear = 1'b0;
        w_clr_target  = clr_row;
        case (r_state)
            IDLE: begin
                clr_ready     = clr_valid;
                w_start_clear = clr_valid || w_auto;
                w_clr_target  = clr_valid ? clr_row : w_auto_row;
                if (!w_start_clear) begin
                    w_gnt0 = wr0_valid && (!wr1_valid || !r_ptr);
                    w_gnt1 = wr1_valid && (!wr0_valid ||  r_ptr);
                end
            end
            CLEAR: busy = 1'b1;
            DONE: begin
                busy     = 1'b1;
                clr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr0_ready = w_gnt0;
    assign wr1_ready = w_gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++)
                r_shadow[i] <= '0;
            r_scan  <= '0;
            address <= '0;
            print   <= '0;
            r_cur   <= '0;
            r_ptr   <= 1'b0;
        end else begin
            r_scan  <= r_scan + 4'd1;
            address <= r_scan;
            print   <= r_shadow[r_scan];
            if (w_start_clear)
                r_cur <= w_clr_target;
            if (w_gnt0) begin
                r_shadow[wr0_addr] <= wr0_data;
                r_ptr              <= 1'b1;
            end
            if (w_gnt1) begin
                r_shadow[wr1_addr] <= wr1_data;
                r_ptr              <= 1'b0;
            end
            // Clear drops every row above cur down by one, then blanks the top row.
            if (r_state == CLEAR) begin
                if (r_cur != 4'd0) begin
                    r_shadow[r_cur] <= r_shadow[4'(r_cur - 4'd1)];
                    r_cur           <= 4'(r_cur - 4'd1);
                end else begin
                    r_shadow[0] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboarded bench for frame_scheduler: display refresh, arbitration, line clear and reset.
module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr0_valid, wr1_valid, clr_valid;
    logic [3:0]  wr0_addr, wr1_addr, clr_row;
    logic [7:0]  wr0_data, wr1_data;
    logic        wr0_ready, wr1_ready, clr_ready, clr_done, busy;
    logic [15:0] row_full;
    logic [3:0]  address;
    logic [7:0]  print;

    frame_scheduler dut (
        .clk(clk), .rst(rst),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .clr_valid(clr_valid), .clr_row(clr_row), .clr_ready(clr_ready), .clr_done(clr_done),
        .busy(busy), .row_full(row_full), .address(address), .print(print)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q [$];
    logic [7:0]  m_shadow [16];
    logic [3:0]  m_scan;
    logic        pend_we, pend_shift;
    logic [3:0]  pend_addr, pend_cur;
    logic [7:0]  pend_data;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
        m_scan = 4'd0;
        exp_q.delete();
        pend_we = 1'b0;
        pend_shift = 1'b0;
    endtask

    task automatic idle_inputs();
        wr0_valid = 0; wr1_valid = 0; clr_valid = 0;
        wr0_addr = 0; wr1_addr = 0; clr_row = 0; wr0_data = 0; wr1_data = 0;
    endtask

    // One clock: push expected display word, apply pending model update, compare after the edge.
    task automatic step();
        logic [11:0] e;
        logic [15:0] exp_full;
        exp_q.push_back({m_scan, m_shadow[m_scan]});
        @(posedge clk);
        if (pend_we) m_shadow[pend_addr] = pend_data;
        if (pend_shift) begin
            if (pend_cur != 4'd0) m_shadow[pend_cur] = m_shadow[4'(pend_cur - 4'd1)];
            else                  m_shadow[0] = 8'h00;
        end
        pend_we = 1'b0;
        pend_shift = 1'b0;
        m_scan = 4'(m_scan + 4'd1);
        #1;
        e = exp_q.pop_front();
        total++;
        if ({address, print} !== e) begin
            bad++;
            $display("FAIL display: got addr=%0d print=%h want addr=%0d print=%h", address, print, e[11:8], e[7:0]);
        end
        for (int i = 0; i < 16; i++) exp_full[i] = (m_shadow[i] == 8'hFF);
        total++;
        if (row_full !== exp_full) begin
            bad++;
            $display("FAIL row_full: got %h want %h", row_full, exp_full);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        total++; if (address !== 4'd0) begin bad++; $display("FAIL reset_address: got %0d want 0", address); end
        total++; if (print !== 8'h00) begin bad++; $display("FAIL reset_print: got %h want 00", print); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_clr_done: got %b want 0", clr_done); end
        total++; if (row_full !== 16'h0) begin bad++; $display("FAIL reset_row_full: got %h want 0000", row_full); end
        total++; if ({wr0_ready, wr1_ready, clr_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_readys: got %b want 000", {wr0_ready, wr1_ready, clr_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step();
            total++;
            if ({wr0_ready, wr1_ready, clr_ready} !== 3'b000) begin
                bad++; $display("FAIL idle_readys: got %b want 000", {wr0_ready, wr1_ready, clr_ready});
            end
        end
    endtask

    task automatic test_write();
        logic seen;
        wr0_valid = 1; wr0_addr = 4'd5; wr0_data = 8'hA5;
        #1;
        total++; if (wr0_ready !== 1'b1) begin bad++; $display("FAIL write_ready0: got %b want 1", wr0_ready); end
        total++; if (wr1_ready !== 1'b0) begin bad++; $display("FAIL write_ready1: got %b want 0", wr1_ready); end
        pend_we = 1; pend_addr = 4'd5; pend_data = 8'hA5;
        step();
        wr0_valid = 0;
        seen = 1'b0;
        for (int k = 0; k < 17; k++) begin
            step();
            if (address === 4'd5 && print === 8'hA5) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL write_display: got seen=%b want 1", seen); end
    endtask

    task automatic test_arbitration();
        logic g;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr0_valid = 1; wr0_addr = 4'(k);     wr0_data = 8'(8'h10 + k);
            wr1_valid = 1; wr1_addr = 4'(8 + k); wr1_data = 8'(8'h80 + k);
            #1;
            g = (k % 2 == 1);
            total++;
            if ({wr0_ready, wr1_ready} !== {!g, g}) begin
                bad++; $display("FAIL arb_grant%0d: got r0r1=%b%b want %b%b", k, wr0_ready, wr1_ready, !g, g);
            end
            pend_we = 1;
            pend_addr = g ? wr1_addr : wr0_addr;
            pend_data = g ? wr1_data : wr0_data;
            step();
        end
        wr0_valid = 0;
        wr1_addr = 4'd14; wr1_data = 8'h5A;
        #1;
        total++; if (wr1_ready !== 1'b1) begin bad++; $display("FAIL arb_single: got %b want 1", wr1_ready); end
        pend_we = 1; pend_addr = 4'd14; pend_data = 8'h5A;
        step();
        wr1_valid = 0;
        for (int k = 0; k < 16; k++) step();
    endtask

    task automatic test_clear();
        int cyc;
        logic [7:0] got [16];
        do_reset();
        wr0_valid = 1;
        wr0_addr = 4'd3; wr0_data = 8'h11; pend_we = 1; pend_addr = 4'd3; pend_data = 8'h11; step();
        wr0_addr = 4'd4; wr0_data = 8'h22; pend_we = 1; pend_addr = 4'd4; pend_data = 8'h22; step();
        wr0_addr = 4'd5; wr0_data = 8'hFF; pend_we = 1; pend_addr = 4'd5; pend_data = 8'hFF; step();
        wr0_valid = 0;
        total++; if (row_full[5] !== 1'b1) begin bad++; $display("FAIL clear_full_before: got %b want 1", row_full[5]); end
        clr_valid = 1; clr_row = 4'd5;
        #1;
        total++; if (clr_ready !== 1'b1) begin bad++; $display("FAIL clear_ready: got %b want 1", clr_ready); end
        step();
        clr_valid = 0;
        cyc = 0;
        while (busy === 1'b1 && clr_done !== 1'b1 && cyc < 20) begin
            if (cyc <= 5) begin pend_shift = 1; pend_cur = 4'(5 - cyc); end
            step();
            cyc++;
        end
        total++; if (cyc !== 6) begin bad++; $display("FAIL clear_length: got %0d want 6", cyc); end
        total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL clear_done_pulse: got %b want 1", clr_done); end
        step();
        total++; if ({clr_done, busy} !== 2'b00) begin
            bad++; $display("FAIL clear_done_once: got done,busy=%b want 00", {clr_done, busy});
        end
        for (int k = 0; k < 16; k++) begin
            step();
            got[address] = print;
        end
        total++; if (got[5] !== 8'h22) begin bad++; $display("FAIL clear_row5: got %h want 22", got[5]); end
        total++; if (got[4] !== 8'h11) begin bad++; $display("FAIL clear_row4: got %h want 11", got[4]); end
        total++; if (got[0] !== 8'h00) begin bad++; $display("FAIL clear_row0: got %h want 00", got[0]); end
        total++; if (row_full[5] !== 1'b0) begin bad++; $display("FAIL clear_full_after: got %b want 0", row_full[5]); end
    endtask

    task automatic test_clear_beats_write();
        int cyc;
        do_reset();
        clr_valid = 1; clr_row = 4'd2;
        wr1_valid = 1; wr1_addr = 4'd7; wr1_data = 8'h3C;
        #1;
        total++; if ({clr_ready, wr1_ready} !== 2'b10) begin
            bad++; $display("FAIL cbw_first: got clr,wr1=%b want 10", {clr_ready, wr1_ready});
        end
        step();
        clr_valid = 0;
        cyc = 0;
        while (busy === 1'b1 && clr_done !== 1'b1 && cyc < 20) begin
            total++; if (wr1_ready !== 1'b0) begin bad++; $display("FAIL cbw_clear_wr1: got %b want 0", wr1_ready); end
            if (cyc <= 2) begin pend_shift = 1; pend_cur = 4'(2 - cyc); end
            step();
            cyc++;
        end
        total++; if (cyc !== 3) begin bad++; $display("FAIL cbw_length: got %0d want 3", cyc); end
        total++; if ({clr_done, wr1_ready} !== 2'b10) begin
            bad++; $display("FAIL cbw_done: got done,wr1=%b want 10", {clr_done, wr1_ready});
        end
        step();
        total++; if (wr1_ready !== 1'b1) begin bad++; $display("FAIL cbw_after: got %b want 1", wr1_ready); end
        pend_we = 1; pend_addr = 4'd7; pend_data = 8'h3C;
        step();
        wr1_valid = 0;
        for (int k = 0; k < 16; k++) step();
    endtask

    task automatic test_reset_midclear();
        do_reset();
        wr0_valid = 1;
        for (int r = 1; r <= 3; r++) begin
            wr0_addr = 4'(r); wr0_data = 8'(8'h41 + r);
            pend_we = 1; pend_addr = 4'(r); pend_data = 8'(8'h41 + r);
            step();
        end
        wr0_valid = 0;
        clr_valid = 1; clr_row = 4'd5;
        step();
        clr_valid = 0;
        pend_shift = 1; pend_cur = 4'd5; step();
        pend_shift = 1; pend_cur = 4'd4; step();
        #2;
        rst = 1'b1;
        #1;
        total++; if ({address, print} !== 12'h000) begin
            bad++; $display("FAIL midrst_display: got addr=%0d print=%h want 0/00", address, print);
        end
        total++; if ({busy, clr_done} !== 2'b00) begin
            bad++; $display("FAIL midrst_fsm: got busy,done=%b want 00", {busy, clr_done});
        end
        total++; if (row_full !== 16'h0) begin bad++; $display("FAIL midrst_full: got %h want 0000", row_full); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL midrst_hold_done: got %b want 0", clr_done); end
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 17; k++) begin
            step();
            total++; if ({busy, clr_done} !== 2'b00) begin
                bad++; $display("FAIL midrst_after: got busy,done=%b want 00", {busy, clr_done});
            end
        end
    endtask

    task automatic test_autoclear();
        do_reset();
        wr0_valid = 1; wr0_addr = 4'd9; wr0_data = 8'hFF;
        pend_we = 1; pend_addr = 4'd9; pend_data = 8'hFF;
        step();
        wr0_valid = 0;
`ifdef FRAME_SCHED_AUTOCLEAR_EN
        begin
            int cyc;
            wr1_valid = 1; wr1_addr = 4'd2; wr1_data = 8'h55;
            #1;
            total++; if ({busy, wr1_ready, clr_ready} !== 3'b000) begin
                bad++; $display("FAIL auto_start: got busy,wr1,clr=%b want 000", {busy, wr1_ready, clr_ready});
            end
            step();
            wr1_valid = 0;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy: got %b want 1", busy); end
            cyc = 0;
            while (busy === 1'b1 && clr_done !== 1'b1 && cyc < 30) begin
                if (cyc <= 9) begin pend_shift = 1; pend_cur = 4'(9 - cyc); end
                step();
                cyc++;
            end
            total++; if (cyc !== 10) begin bad++; $display("FAIL auto_length: got %0d want 10", cyc); end
            step();
        end
`else
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL noauto_busy: got %b want 0", busy); end
        end
        total++; if (row_full[9] !== 1'b1) begin bad++; $display("FAIL noauto_full: got %b want 1", row_full[9]); end
`endif
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_write();
        test_arbitration();
        test_clear();
        test_clear_beats_write();
        test_reset_midclear();
        test_autoclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
